// File: rtl/busca_instrucao.sv
// busca_instrucao -- instruction-fetch stage of the 16-bit MIPS datapath.
//
// Owns the program counter, presents it to the combinational instruction ROM
// and registers the returned word into the IF/ID pipeline register. Supports
// sequential advance (+2), taken branches and jumps resolved in decode, decode
// stalls, and counts every instruction loaded into IF/ID as valid.
//
// Ports:
//   clk            in   1   system clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   pc             out  16  fetch address to memoria_instrucao
//   instrucao_mem  in   16  ROM word at pc (same cycle)
//   parar          in   1   decode stall: hold PC and IF/ID
//   desvio         in   1   branch taken for the instruction in IF/ID
//   desvio_offset  in   8   signed word offset of that branch
//   salto          in   1   jump for the instruction in IF/ID
//   salto_alvo     in   16  absolute jump target (bit 0 ignored)
//   if_valido      out  1   IF/ID holds a real instruction
//   if_instrucao   out  16  IF/ID instruction
//   if_pc          out  16  byte address of if_instrucao
//   contador_busca out  16  count of valid instructions loaded into IF/ID

module busca_instrucao #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] pc,
    input  logic [15:0] instrucao_mem,
    input  logic        parar,
    input  logic        desvio,
    input  logic [7:0]  desvio_offset,
    input  logic        salto,
    input  logic [15:0] salto_alvo,
    output logic        if_valido,
    output logic [15:0] if_instrucao,
    output logic [15:0] if_pc,
    output logic [15:0] contador_busca
);

    logic        faz_salto;
    logic        faz_desvio;
    logic        redireciona;
    logic        carrega;
    logic [15:0] alvo_desvio;
    logic [15:0] pc_prox;

    // Control transfers only belong to a real instruction in IF/ID; a bubble
    // cannot redirect fetch.
    assign faz_salto   = salto & if_valido;
    assign faz_desvio  = desvio & if_valido & ~salto;
    assign redireciona = faz_salto | faz_desvio;
    assign carrega     = ~redireciona & ~parar;

    // Sign-extended word offset scaled to bytes: 7 sign copies + 8 bits + 0.
    assign alvo_desvio = if_pc + 16'd2 + {{7{desvio_offset[7]}}, desvio_offset, 1'b0};

    always_comb begin
        pc_prox = pc + 16'd2;
        if (faz_salto) begin
            pc_prox = {salto_alvo[15:1], 1'b0};
        end else if (faz_desvio) begin
            pc_prox = alvo_desvio;
        end else if (parar) begin
            pc_prox = pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= PC_RESET;
            if_valido      <= 1'b0;
            if_instrucao   <= '0;
            if_pc          <= '0;
            contador_busca <= '0;
        end else begin
            pc <= pc_prox;
            if (redireciona) begin
                // Flush: the word fetched this cycle is on the wrong path.
                if_valido <= 1'b0;
            end else if (carrega) begin
                if_valido      <= 1'b1;
                if_instrucao   <= instrucao_mem;
                if_pc          <= pc;
                contador_busca <= contador_busca + 16'd1;
            end
        end
    end

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction-fetch stage of the 16-bit MIPS datapath. It owns the program counter, drives the address port of `memoria_instrucao` (combinational ROM, 16-bit instruction per even address), and registers the returned word into the IF/ID pipeline register consumed by decode. It handles sequential advance (+2), taken branches, jumps, decode stalls and the resulting flush, and keeps a count of issued instructions.

## Interface

Parameters:
- `PC_RESET`, default 16'h0000: PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc`  out  16  fetch address to `memoria_instrucao`.
- `instrucao_mem`  in  16  ROM data for `pc`; combinational, valid in the same cycle.
- `parar`  in  1  decode stall; hold PC and IF/ID.
- `desvio`  in  1  branch taken for the instruction currently in IF/ID.
- `desvio_offset`  in  8  signed word offset of that branch.
- `salto`  in  1  jump for the instruction currently in IF/ID.
- `salto_alvo`  in  16  absolute jump target in bytes; bit 0 ignored and forced to 0.
- `if_valido`  out  1  IF/ID holds a real instruction.
- `if_instrucao`  out  16  IF/ID instruction.
- `if_pc`  out  16  byte address of `if_instrucao`.
- `contador_busca`  out  16  count of instructions loaded into IF/ID with `if_valido`=1.

## Operation

- Reset (`rst_n`=0, asynchronous): `pc`=`PC_RESET`, `if_valido`=0, `if_instrucao`=16'h0000, `if_pc`=16'h0000, `contador_busca`=0. Reset asserted mid-operation discards the in-flight instruction immediately.
- Next-PC selection, evaluated every cycle, priority high to low:
  1. `salto`=1: `pc` <= {`salto_alvo`[15:1],1'b0}.
  2. `desvio`=1: `pc` <= `if_pc` + 2 + (sign_extend(`desvio_offset`) << 1), modulo 2^16.
  3. `parar`=1: `pc` holds.
  4. Otherwise: `pc` <= `pc` + 2, modulo 2^16 (16'hFFFE wraps to 16'h0000).
- `salto` and `desvio` are honoured only when `if_valido`=1. If `if_valido`=0 they are ignored.
- IF/ID update:
  - Redirect (case 1 or 2): `if_valido` <= 0 (flush). `if_instrucao` and `if_pc` may hold any value. Redirect overrides `parar`.
  - `parar`=1, no redirect: IF/ID holds all fields.
  - Otherwise: `if_instrucao` <= `instrucao_mem`, `if_pc` <= `pc`, `if_valido` <= 1.
- `contador_busca` increments by 1, wrapping at 16'hFFFF to 0, on each edge where IF/ID loads under "Otherwise". It does not increment on stall, flush or reset.
- Addresses beyond the ROM range are not checked here. The ROM returns its out-of-range value and fetch proceeds normally.

## Timing

- Fetch latency is 1 cycle. The word at `pc` during cycle N appears on `if_instrucao` with `if_valido`=1 in cycle N+1.
- First valid instruction: the first edge after `rst_n` rises loads the word at `PC_RESET`.
- A taken branch or jump costs exactly 1 bubble. Redirect is asserted in cycle N. In cycle N+1, `pc` equals the target and `if_valido`=0. In cycle N+2, IF/ID holds the target instruction.
- Stall is zero-latency. While `parar`=1, `pc`, `if_*` and `contador_busca` are frozen on every edge. Fetch resumes on the first edge with `parar`=0.
- `salto` and `desvio` both asserted: `salto` wins.
- `pc` is always even. No output changes except on a clock edge or asynchronous reset.

## Test plan

- Reset and sequential fetch: hold `rst_n`=0, then release with no control inputs.
  - During reset: `pc`=0, `if_valido`=0, `contador_busca`=0.
  - After 5 edges: `pc`=10, `if_pc`=8, `if_valido`=1, `contador_busca`=5. `if_instrucao` equals the ROM word at 8.
- Stall: assert `parar` for 3 cycles while `pc`=6.
  - All outputs are frozen for 3 edges.
  - On release, `pc`=8 after the next edge and `if_pc`=6.
  - `contador_busca` does not advance during the stall.
- Branch forward and backward:
  - With `if_pc`=16'h0010, `desvio`=1, `desvio_offset`=8'h03: next `pc`=16'h0018, `if_valido`=0 for 1 cycle, then `if_pc`=16'h0018.
  - With `desvio_offset`=8'hFC: next `pc`=16'h000A.
- Jump priority and masking:
  - `salto`=1, `salto_alvo`=16'h0041, `desvio`=1, `parar`=1: next `pc`=16'h0040, `if_valido`=0.
  - The same inputs with `if_valido`=0: ignored, `pc` holds because `parar`=1.
- Wrap-around:
  - `PC_RESET`=16'hFFFC: `pc` sequence is FFFC, FFFE, 0000.
  - `if_pc`=16'hFFFE with `desvio_offset`=8'h01: `pc`=16'h0002.
- Asynchronous reset mid-stream: drop `rst_n` between edges during sequential fetch.
  - All outputs return to reset values immediately, without waiting for an edge.
  - Fetch restarts at `PC_RESET` after `rst_n` is released.
